// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with valid/ready on both sides.
// Optional empty-bypass path enabled by defining FIFO_BYPASS_EN.
module sync_fifo #(
    parameter int WIDTH       = 32,
    parameter int DEPTH       = 4,
    parameter int AFULL_LEVEL = DEPTH - 1,
    localparam int AW         = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW:0]      count,
    output logic             almost_full
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [AW:0] AF_CNT   = (AW + 1)'(AFULL_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt_q;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             wr_en;
    logic             rd_en;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == FULL_CNT);

    assign in_ready = ~rst & ~full;
    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;

`ifdef FIFO_BYPASS_EN
    // When empty the producer's word is offered straight to the consumer;
    // it is only stored if the consumer does not take it this cycle.
    assign out_valid = ~rst & (~empty | in_valid);
    assign out       = empty ? in : mem[rptr];
    assign wr_en     = push & ~(empty & out_ready);
`else
    assign out_valid = ~rst & ~empty;
    assign out       = mem[rptr];
    assign wr_en     = push;
`endif

    assign rd_en       = pop & ~empty;
    assign count       = rst ? '0 : cnt_q;
    assign almost_full = ~rst & (cnt_q >= AF_CNT);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wptr] <= in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_en) begin
                rptr <= rptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: tb/tb_sync_fifo.sv
// Randomised and directed bench for sync_fifo against a queue-based model.
// Expectations adapt to FIFO_BYPASS_EN when it is defined.
module tb_sync_fifo;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int AF = 3;
`ifdef FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] in;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   count;
    logic         almost_full;

    int n_chk = 0;
    int n_err = 0;

    logic [W-1:0] q[$];
    logic [W-1:0] got_q[$];
    logic         obs_ir;
    logic         obs_ov;
    logic [W-1:0] obs_out;
    logic         last_acc;

    sync_fifo #(
        .WIDTH(W),
        .DEPTH(D),
        .AFULL_LEVEL(AF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in(in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .out(out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .count(count),
        .almost_full(almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive, check against the model, then advance it.
    task automatic cycle(input logic r, input logic iv,
                         input logic [W-1:0] d, input logic ordy);
        logic         e_ir;
        logic         e_ov;
        logic         take;
        int           sz;
        rst       = r;
        in_valid  = iv;
        in        = d;
        out_ready = ordy;
        @(negedge clk);
        sz   = q.size();
        e_ir = !r && (sz < D);
        e_ov = !r && (sz != 0 || (BYP && iv));
        chk("in_ready", {63'd0, in_ready}, {63'd0, e_ir});
        chk("out_valid", {63'd0, out_valid}, {63'd0, e_ov});
        chk("count", {61'd0, count}, r ? 64'd0 : 64'(sz));
        chk("almost_full", {63'd0, almost_full},
            {63'd0, !r && sz >= AF});
        if (e_ov) begin
            chk("out", {32'd0, out}, {32'd0, (sz != 0) ? q[0] : d});
        end
        obs_ir   = in_ready;
        obs_ov   = out_valid;
        obs_out  = out;
        last_acc = e_ir && iv;
        take     = e_ov && ordy;
        @(posedge clk);
        #1;
        if (r) begin
            q.delete();
        end else begin
            if (last_acc) q.push_back(d);
            if (take) begin
                got_q.push_back(obs_out);
                void'(q.pop_front());
            end
        end
    endtask

    initial begin
        int sent;
        int n;
        logic [W-1:0] base;
        rst = 1'b1;
        in = '0;
        in_valid = 1'b0;
        out_ready = 1'b0;

        cycle(1'b1, 1'b0, '0, 1'b0);
        cycle(1'b1, 1'b1, 32'h99, 1'b1);

        // Fill
        cycle(1'b0, 1'b1, 32'h11, 1'b0);
        cycle(1'b0, 1'b1, 32'h22, 1'b0);
        cycle(1'b0, 1'b1, 32'h33, 1'b0);
        cycle(1'b0, 1'b1, 32'h44, 1'b0);
        cycle(1'b0, 1'b1, 32'h55, 1'b0);
        chk("fill_5th_ready", {63'd0, obs_ir}, 64'd0);

        // Drain
        got_q.delete();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        chk("drain_n", 64'(got_q.size()), 64'd4);
        if (got_q.size() == 4) begin
            chk("drain0", {32'd0, got_q[0]}, 64'h11);
            chk("drain1", {32'd0, got_q[1]}, 64'h22);
            chk("drain2", {32'd0, got_q[2]}, 64'h33);
            chk("drain3", {32'd0, got_q[3]}, 64'h44);
        end

        // Simultaneous push/pop at count=2
        cycle(1'b0, 1'b1, 32'h100, 1'b0);
        cycle(1'b0, 1'b1, 32'h101, 1'b0);
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 32'h200 + 32'(i), 1'b1);
            chk("simul_count", {61'd0, count}, 64'd2);
        end
        chk("simul_n", 64'(got_q.size()), 64'd8);
        if (got_q.size() == 8) begin
            chk("simul0", {32'd0, got_q[0]}, 64'h100);
            chk("simul1", {32'd0, got_q[1]}, 64'h101);
            for (int i = 2; i < 8; i++)
                chk("simul_seq", {32'd0, got_q[i]}, 64'h200 + 64'(i - 2));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);

        // Wrap with random stalls
        got_q.delete();
        sent = 0;
        n = 0;
        while ((sent < 10 || got_q.size() < 10) && n < 300) begin
            cycle(1'b0, (sent < 10) && ($urandom % 2 == 0), 32'(sent),
                  ($urandom % 3 != 0));
            if (last_acc) sent++;
            n++;
        end
        chk("wrap_n", 64'(got_q.size()), 64'd10);
        for (int i = 0; i < 10 && i < got_q.size(); i++)
            chk("wrap_seq", {32'd0, got_q[i]}, 64'(i));

        // Reset mid-operation at count=3
        cycle(1'b0, 1'b1, 32'h61, 1'b0);
        cycle(1'b0, 1'b1, 32'h62, 1'b0);
        cycle(1'b0, 1'b1, 32'h63, 1'b0);
        chk("pre_rst_count", {61'd0, count}, 64'd3);
        cycle(1'b1, 1'b0, '0, 1'b0);
        chk("rst_ready", {63'd0, obs_ir}, 64'd0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("post_rst_ready", {63'd0, obs_ir}, 64'd1);
        chk("post_rst_valid", {63'd0, obs_ov}, 64'd0);
        cycle(1'b0, 1'b1, 32'hAB, 1'b0);
        got_q.delete();
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("rst_fresh_n", 64'(got_q.size()), 64'd1);
        if (got_q.size() == 1) chk("rst_fresh", {32'd0, got_q[0]}, 64'hAB);

        // Empty-bypass behaviour
        cycle(1'b0, 1'b1, 32'hCD, 1'b1);
        chk("byp_ov", {63'd0, obs_ov}, {63'd0, BYP});
        cycle(1'b0, 1'b0, '0, 1'b1);
        chk("byp_late_ov", {63'd0, obs_ov}, {63'd0, !BYP});
        if (!BYP) chk("byp_late_out", {32'd0, obs_out}, 64'hCD);
        cycle(1'b0, 1'b1, 32'hCD, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        chk("byp_store_cnt", {61'd0, count}, 64'd1);
        chk("byp_store_out", {32'd0, out}, 64'hCD);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Random soak
        base = 32'h1000;
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 60) == 0, ($urandom % 4) != 0, base,
                  ($urandom % 3) != 0);
            base = base + 1;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
